timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_ctrl_cnt_en.sv | 26 ++
 rtl/timer_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: FSM state encoding,
// reload mode encoding and the default counter width.
package timer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      ONE_SHOT    = 1'b0,
      AUTO_RELOAD = 1'b1
   } mode_t;

endpackage

// File: rtl/timer_ctrl_cnt_en.sv
// Counter datapath for timer_ctrl: modulo-2^WIDTH up-counter with a
// synchronous clear that takes priority over the count enable.
module cnt_en
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             sclr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   // Clear wins over enable; increment wraps naturally at 2^WIDTH.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         q <= '0;
      end else if (sclr) begin
         q <= '0;
      end else if (en) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: IDLE/RUN FSM with latched preset and mode, one-shot
// or auto-reload terminal count, registered done pulse.
// Optional sticky interrupt (irq/irq_ack) built when TIMER_CTRL_IRQ_EN
// is defined.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             mode,
   input  logic [WIDTH-1:0] preset,
`ifdef TIMER_CTRL_IRQ_EN
   input  logic             irq_ack,
   output logic             irq,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           state;
   mode_t            mode_q;
   logic [WIDTH-1:0] preset_q;
   logic             term;
   logic             advance;
   logic             sclr;
   logic             en;
   logic             done_next;

   // Next-cycle counter controls and terminal-count detection.
   always_comb begin
      term      = (count == preset_q);
      advance   = (state == RUN) && !stop && !hold;
      done_next = advance && term;
      en        = advance && !term;
      sclr      = ((state == IDLE) && start && !stop) ||
                  (done_next && (mode_q == AUTO_RELOAD));
   end

   cnt_en #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clock   (clock),
      .clear_n (clear_n),
      .sclr    (sclr),
      .en      (en),
      .q       (count)
   );

   // FSM with latched configuration and registered busy/done outputs.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         preset_q <= '0;
         mode_q   <= ONE_SHOT;
      end else begin
         done <= done_next;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  preset_q <= preset;
                  mode_q   <= mode_t'(mode);
                  state    <= RUN;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (stop || (done_next && (mode_q == ONE_SHOT))) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TIMER_CTRL_IRQ_EN
   // Sticky interrupt: rises with done, acknowledge clears, set wins.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         irq <= 1'b0;
      end else if (done_next) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule
